// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: paces a glyph byte stream into a KS0108 64x64 half.
// clk/rst_n; data_in/data_valid in, en out; lcd_* bus; frame_done pulse.
// LCD_FRAME_BOTH_HALVES_EN: mirror every write onto both panel halves.
module lcd_frame_writer #(
  parameter int RST_CYCLES = 100,
  parameter int E_CYCLES   = 4,
  parameter int HALF_SEL   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       en,
  output logic       lcd_rst,
  output logic [1:0] lcd_cs,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       frame_done
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int WW = $clog2(2 * E_CYCLES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(2 * E_CYCLES - 1);
  localparam logic [WW-1:0] E_LO   = WW'(1);
  localparam logic [WW-1:0] E_HI   = WW'(E_CYCLES);

`ifdef LCD_FRAME_BOTH_HALVES_EN
  localparam logic [1:0] CS = 2'b11;
`else
  localparam logic [1:0] CS = (HALF_SEL != 0) ? 2'b10 : 2'b01;
`endif

  typedef enum logic [2:0] {
    RST_WAIT,
    INIT_ON,
    INIT_START,
    SET_PAGE,
    SET_COL,
    REQ,
    WAIT_VALID,
    WRITE_DATA
  } state_t;

  state_t        state, state_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic [2:0]    page, page_nx;
  logic [5:0]    col, col_nx;
  logic [7:0]    byte_q, byte_nx;
  logic [7:0]    db_nx;
  logic          done_nx;
  logic          wr_st, wr_end, wr_nx;
  logic          e_nx, rs_nx, en_nx, rst_nx;

  assign wr_st = (state == INIT_ON) || (state == INIT_START) ||
                 (state == SET_PAGE) || (state == SET_COL) ||
                 (state == WRITE_DATA);
  assign wr_end = wr_st && (wcnt == W_LAST);

  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    page_nx  = page;
    col_nx   = col;
    byte_nx  = byte_q;
    done_nx  = 1'b0;
    db_nx    = lcd_db;
    wcnt_nx  = (wr_st && !wr_end) ? wcnt + 1'b1 : '0;

    unique case (state)
      RST_WAIT: begin
        if (rcnt == R_LAST) begin
          rcnt_nx  = '0;
          state_nx = INIT_ON;
        end else begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
      INIT_ON:    if (wr_end) state_nx = INIT_START;
      INIT_START: if (wr_end) state_nx = SET_PAGE;
      SET_PAGE:   if (wr_end) state_nx = SET_COL;
      SET_COL:    if (wr_end) state_nx = REQ;
      REQ:        state_nx = WAIT_VALID;
      WAIT_VALID: begin
        // a missed valid re-requests, so en repeats every 2 cycles
        if (data_valid) begin
          byte_nx  = data_in;
          state_nx = WRITE_DATA;
        end else begin
          state_nx = REQ;
        end
      end
      WRITE_DATA: begin
        if (wr_end) begin
          col_nx = col + 1'b1;
          if (col == 6'd63) begin
            page_nx  = page + 1'b1;
            done_nx  = (page == 3'd7);
            state_nx = SET_PAGE;
          end else begin
            state_nx = REQ;
          end
        end
      end
      default: state_nx = RST_WAIT;
    endcase

    // outputs are registered, so derive them from the next state
    unique case (state_nx)
      INIT_ON:    db_nx = 8'h3F;
      INIT_START: db_nx = 8'hC0;
      SET_PAGE:   db_nx = {5'b10111, page_nx};
      SET_COL:    db_nx = 8'h40;
      WRITE_DATA: db_nx = byte_nx;
      default:    db_nx = lcd_db;
    endcase

    wr_nx  = (state_nx == INIT_ON) || (state_nx == INIT_START) ||
             (state_nx == SET_PAGE) || (state_nx == SET_COL) ||
             (state_nx == WRITE_DATA);
    e_nx   = wr_nx && (wcnt_nx >= E_LO) && (wcnt_nx <= E_HI);
    rs_nx  = (state_nx == WRITE_DATA);
    en_nx  = (state_nx == REQ);
    rst_nx = (state_nx != RST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_WAIT;
      rcnt       <= '0;
      wcnt       <= '0;
      page       <= '0;
      col        <= '0;
      byte_q     <= '0;
      en         <= 1'b0;
      lcd_rst    <= 1'b0;
      lcd_cs     <= CS;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_db     <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      rcnt       <= rcnt_nx;
      wcnt       <= wcnt_nx;
      page       <= page_nx;
      col        <= col_nx;
      byte_q     <= byte_nx;
      en         <= en_nx;
      lcd_rst    <= rst_nx;
      lcd_cs     <= CS;
      lcd_e      <= e_nx;
      lcd_rs     <= rs_nx;
      lcd_rw     <= 1'b0;
      lcd_db     <= db_nx;
      frame_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: random-latency byte source plus LCD bus monitor,
// checked against a page/column write-sequence model.
module tb_lcd_frame_writer;

  localparam int RST = 100;
  localparam int E   = 4;
`ifdef LCD_FRAME_BOTH_HALVES_EN
  localparam logic [1:0] EXP_CS = 2'b11;
`else
  localparam logic [1:0] EXP_CS = 2'b01;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       en, lcd_rst, lcd_e, lcd_rs, lcd_rw, frame_done;
  logic [1:0] lcd_cs;
  logic [7:0] lcd_db;

  lcd_frame_writer #(
    .RST_CYCLES(RST),
    .E_CYCLES(E),
    .HALF_SEL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .data_valid(data_valid),
    .en(en),
    .lcd_rst(lcd_rst),
    .lcd_cs(lcd_cs),
    .lcd_e(lcd_e),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_db(lcd_db),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h",
             tag, obs, exp);
    end
  endtask

  int cyc, wr_idx, dcount, acc, fd_count;
  int e_width, rise_cyc, vcyc;
  bit prev_e, prev_en, prev_fd;
  bit pending, ans, no_answer, first_byte, spur_req;
  logic [7:0] cur_db, last_db;
  logic       cur_rs, last_rs;
  logic [7:0] q[$];

  task automatic model_reset();
    wr_idx = 0; dcount = 0; acc = 0; fd_count = 0;
    e_width = 0; rise_cyc = 0; vcyc = 0;
    prev_e = 0; prev_en = 0; prev_fd = 0;
    pending = 0; ans = 0; spur_req = 0;
    q.delete();
  endtask

  task automatic cycle();
    int n, k, p, gap;
    logic [7:0] edb, b;
    logic ers;
    @(negedge clk);
    cyc++;
    k = -1;
    if (frame_done) begin
      chk("fd_single", prev_fd, 1'b0);
      chk("fd_at_frame_end",
          (dcount > 0) && (dcount % 512 == 0), 1'b1);
      fd_count++;
    end
    if (lcd_e && !prev_e) begin
      edb = 8'h00;
      ers = 1'b0;
      if (wr_idx == 0) edb = 8'h3F;
      else if (wr_idx == 1) edb = 8'hC0;
      else begin
        n = wr_idx - 2;
        k = n % 66;
        p = (n / 66) % 8;
        if (k == 0) edb = 8'hB8 | 8'(p);
        else if (k == 1) edb = 8'h40;
        else begin
          ers = 1'b1;
          chk("byte_available", q.size() > 0, 1'b1);
          if (q.size() > 0) edb = q.pop_front();
        end
      end
      chk("wr_rs", lcd_rs, ers);
      chk("wr_db", lcd_db, edb);
      chk("wr_cs", lcd_cs, EXP_CS);
      chk("wr_rw", lcd_rw, 1'b0);
      if (wr_idx > 0 && !ers) begin
        chk("cmd_period", cyc - rise_cyc, 2 * E);
      end
      if (k == 0 && dcount > 0 && dcount % 512 == 0) begin
        chk("fd_before_b8", fd_count, dcount / 512);
      end
      rise_cyc = cyc;
      cur_db = lcd_db;
      cur_rs = lcd_rs;
      e_width = 1;
      wr_idx++;
      if (ers) begin
        dcount++;
        last_db = lcd_db;
        last_rs = lcd_rs;
      end
    end else if (lcd_e) begin
      e_width++;
      chk("db_stable", lcd_db, cur_db);
      chk("rs_stable", lcd_rs, cur_rs);
    end else if (prev_e) begin
      chk("e_width", e_width, E);
    end
    if (en) begin
      chk("en_b2b", prev_en, 1'b0);
      chk("en_in_write", lcd_e, 1'b0);
      if (ans) begin
        gap = 2 * E + 1 + ((acc % 64 == 0) ? 4 * E : 0);
        chk("en_gap", cyc - vcyc, gap);
        ans = 0;
      end
    end
    prev_e = lcd_e;
    prev_en = en;
    prev_fd = frame_done;
    data_valid = 1'b0;
    if (pending) begin
      b = first_byte ? 8'hA5 : 8'($urandom);
      first_byte = 0;
      data_valid = 1'b1;
      data_in = b;
      q.push_back(b);
      vcyc = cyc;
      ans = 1;
      acc++;
      pending = 0;
    end else if (spur_req) begin
      data_valid = 1'b1;
      data_in = 8'h5A;
      spur_req = 0;
    end
    if (en && !no_answer &&
        (first_byte || $urandom_range(3) != 0))
      pending = 1;
  endtask

  task automatic check_reset_vals();
    chk("rst_en", en, 1'b0);
    chk("rst_lcd_rst", lcd_rst, 1'b0);
    chk("rst_cs", lcd_cs, EXP_CS);
    chk("rst_e", lcd_e, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_db", lcd_db, 8'h00);
    chk("rst_fd", frame_done, 1'b0);
  endtask

  task automatic release_and_count();
    int cnt;
    cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (lcd_rst) break;
      cnt++;
    end
    chk("rst_low_cycles", cnt, RST);
  endtask

  initial begin
    int en_cnt;
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = 8'h00;
    cyc = 0;
    no_answer = 1;
    first_byte = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();

    release_and_count();
    spur_req = 1;

    for (int i = 0; i < 500 && !en; i++) cycle();
    chk("first_en_seen", en, 1'b1);
    en_cnt = 1;
    for (int i = 0; i < 19; i++) begin
      cycle();
      if (en) en_cnt++;
    end
    chk("stall_en_pulses", en_cnt, 10);
    chk("stall_no_data", dcount, 0);
    no_answer = 0;

    for (int i = 0; i < 200 && dcount < 1; i++) cycle();
    chk("first_byte_db", last_db, 8'hA5);
    chk("first_byte_rs", last_rs, 1'b1);

    for (int i = 0; i < 30000 && wr_idx < 2 + 8 * 66 + 1; i++)
      cycle();
    chk("frame_reached", wr_idx >= 2 + 8 * 66 + 1, 1'b1);
    chk("fd_count_frame", fd_count, 1);

    for (int i = 0; i < 20000 && dcount < 512 + 3 * 64 + 20; i++)
      cycle();
    chk("mid_frame_reached", dcount, 512 + 3 * 64 + 20);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    data_valid = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_vals();
    release_and_count();

    for (int i = 0; i < 5000 && dcount < 70; i++) cycle();
    chk("post_reset_data", dcount >= 70, 1'b1);
    chk("post_reset_fd", fd_count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
